clk_period_meter: RTL and testbench

Receive-side companion to the team's clock dividers. Takes a slow divided clock or tick signal (`sig_in`) back into the fast system clock domain and synchronizes it. It produces a one-cycle pulse on each rising edge, measures the period in fast-clock cycles, and reports lock against an expected period plus a loss-of-signal timeout. Used by bench and on-board self-check logic to confirm a divider runs at the configured rate.

---
 rtl/clk_period_meter.sv | 185 ++++++++++++++++++
 tb/tb_clk_period_meter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/clk_period_meter.sv
// rtl/clk_period_meter.sv - synchronizes sig_in, measures its period in clk cycles, reports lock and signal loss
// Optional DUTY_MEASURE_EN adds the high_time port (high phase of the last measured period).
module clk_period_meter #(
    parameter int CNT_W      = 16,
    parameter int EXP_PERIOD = 20,
    parameter int TOL        = 1,
    parameter int LOCK_COUNT = 3,
    parameter int TIMEOUT    = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sig_in,
    output logic             edge_pulse,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
`ifdef DUTY_MEASURE_EN
    output logic [CNT_W-1:0] high_time,
`endif
    output logic             timeout
);

    localparam int LC_W = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);

    localparam logic [CNT_W:0]   TOL_LO  = (CNT_W+1)'((EXP_PERIOD > TOL) ? (EXP_PERIOD - TOL) : 0);
    localparam logic [CNT_W:0]   TOL_HI  = (CNT_W+1)'(EXP_PERIOD + TOL);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [LC_W-1:0]  LC_MAX  = LC_W'(LOCK_COUNT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MEASURE = 2'd1,
        S_LOST    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             s1_q, s2_q, s3_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LC_W-1:0]  lock_cnt_q, lock_cnt_d;
    logic             edge_q;
    logic [CNT_W-1:0] period_q, period_d;
    logic             pv_q, pv_d;
    logic             locked_q, locked_d;
    logic             timeout_q, timeout_d;
`ifdef DUTY_MEASURE_EN
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] hcnt_inc;
`endif

    logic             rise;
    logic [CNT_W-1:0] cnt_inc;
    logic             in_tol;
    logic [LC_W-1:0]  lock_inc;

    assign rise = s2_q & ~s3_q;

    // cnt_inc doubles as the new period: cycles between rises = count + 1
    assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    assign in_tol   = ({1'b0, cnt_inc} >= TOL_LO) && ({1'b0, cnt_inc} <= TOL_HI);
    assign lock_inc = (lock_cnt_q >= LC_MAX) ? LC_MAX : lock_cnt_q + LC_W'(1);
`ifdef DUTY_MEASURE_EN
    assign hcnt_inc = (hcnt_q == CNT_MAX) ? hcnt_q : hcnt_q + CNT_W'(1);
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lock_cnt_d = lock_cnt_q;
        period_d   = period_q;
        pv_d       = 1'b0;
        locked_d   = locked_q;
        timeout_d  = timeout_q;
`ifdef DUTY_MEASURE_EN
        hcnt_d     = hcnt_q;
        high_d     = high_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    state_d = S_MEASURE;
                    cnt_d   = '0;
`ifdef DUTY_MEASURE_EN
                    hcnt_d  = '0;
`endif
                end
            end
            S_MEASURE: begin
                if (rise) begin
                    period_d = cnt_inc;
                    pv_d     = 1'b1;
                    cnt_d    = '0;
`ifdef DUTY_MEASURE_EN
                    high_d   = hcnt_inc;
                    hcnt_d   = '0;
`endif
                    if (in_tol) begin
                        lock_cnt_d = lock_inc;
                        locked_d   = (lock_inc == LC_MAX);
                    end else begin
                        lock_cnt_d = '0;
                        locked_d   = 1'b0;
                    end
                end else if (cnt_q == TO_LAST) begin
                    state_d    = S_LOST;
                    timeout_d  = 1'b1;
                    locked_d   = 1'b0;
                    lock_cnt_d = '0;
                    cnt_d      = '0;
`ifdef DUTY_MEASURE_EN
                    hcnt_d     = '0;
`endif
                end else begin
                    cnt_d = cnt_inc;
`ifdef DUTY_MEASURE_EN
                    if (s2_q) begin
                        hcnt_d = hcnt_inc;
                    end
`endif
                end
            end
            S_LOST: begin
                cnt_d = '0;
                if (rise) begin
                    state_d    = S_MEASURE;
                    timeout_d  = 1'b0;
                    lock_cnt_d = '0;
`ifdef DUTY_MEASURE_EN
                    hcnt_d     = '0;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            s3_q       <= 1'b0;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            lock_cnt_q <= '0;
            edge_q     <= 1'b0;
            period_q   <= '0;
            pv_q       <= 1'b0;
            locked_q   <= 1'b0;
            timeout_q  <= 1'b0;
`ifdef DUTY_MEASURE_EN
            hcnt_q     <= '0;
            high_q     <= '0;
`endif
        end else begin
            s1_q       <= sig_in;
            s2_q       <= s1_q;
            s3_q       <= s2_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lock_cnt_q <= lock_cnt_d;
            edge_q     <= rise;
            period_q   <= period_d;
            pv_q       <= pv_d;
            locked_q   <= locked_d;
            timeout_q  <= timeout_d;
`ifdef DUTY_MEASURE_EN
            hcnt_q     <= hcnt_d;
            high_q     <= high_d;
`endif
        end
    end

    assign edge_pulse   = edge_q;
    assign period       = period_q;
    assign period_valid = pv_q;
    assign locked       = locked_q;
    assign timeout      = timeout_q;
`ifdef DUTY_MEASURE_EN
    assign high_time    = high_q;
`endif

endmodule

// File: tb/tb_clk_period_meter.sv
// tb/tb_clk_period_meter.sv - self-checking bench for clk_period_meter against an event-level reference model
module tb_clk_period_meter;

    localparam int CNT_W      = 16;
    localparam int EXP_PERIOD = 20;
    localparam int TOL        = 1;
    localparam int LOCK_COUNT = 3;
    localparam int TIMEOUT    = 1000;
    localparam int MAXC       = (1 << CNT_W) - 1;

    localparam int M_IDLE = 0;
    localparam int M_MEAS = 1;
    localparam int M_LOST = 2;

    logic             clk;
    logic             reset;
    logic             sig_in;
    logic             edge_pulse;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             locked;
    logic             timeout;
`ifdef DUTY_MEASURE_EN
    logic [CNT_W-1:0] high_time;
`endif

    clk_period_meter #(
        .CNT_W      (CNT_W),
        .EXP_PERIOD (EXP_PERIOD),
        .TOL        (TOL),
        .LOCK_COUNT (LOCK_COUNT),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sig_in       (sig_in),
        .edge_pulse   (edge_pulse),
        .period       (period),
        .period_valid (period_valid),
        .locked       (locked),
`ifdef DUTY_MEASURE_EN
        .high_time    (high_time),
`endif
        .timeout      (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: rises are events in time; each sampled rise becomes visible two edges later.
    int   cyc;
    int   mode;
    int   last;
    int   good;
    int   hi_acc;
    logic prev_v;
    int   ev_t[$];
    int   ev_h[$];
    logic exp_ep, exp_pv, exp_lk, exp_to;
    int   exp_period, exp_ht;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        cyc = 0; mode = M_IDLE; last = 0; good = 0; hi_acc = 0; prev_v = 1'b0;
        ev_t.delete(); ev_h.delete();
        exp_ep = 0; exp_pv = 0; exp_lk = 0; exp_to = 0; exp_period = 0; exp_ht = 0;
    endtask

    task automatic model_edge(input logic v);
        bit ev;
        int hi;
        int p;
        cyc++;
        ev = 0; hi = 0;
        exp_ep = 0; exp_pv = 0;
        if (ev_t.size() > 0 && ev_t[0] == cyc) begin
            ev = 1; hi = ev_h[0];
            void'(ev_t.pop_front()); void'(ev_h.pop_front());
        end
        if (ev) begin
            exp_ep = 1;
            if (mode == M_MEAS) begin
                p = cyc - last;
                if (p > MAXC) p = MAXC;
                exp_period = p; exp_pv = 1; exp_ht = hi;
                if (p >= EXP_PERIOD - TOL && p <= EXP_PERIOD + TOL) begin
                    if (good < LOCK_COUNT) good++;
                end else begin
                    good = 0;
                end
                exp_lk = (good == LOCK_COUNT);
            end else begin
                mode = M_MEAS; exp_to = 0; good = 0;
            end
            last = cyc;
        end else if (mode == M_MEAS && cyc - last == TIMEOUT) begin
            mode = M_LOST; exp_to = 1; exp_lk = 0; good = 0;
        end
        if (v && !prev_v) begin
            ev_t.push_back(cyc + 2); ev_h.push_back(hi_acc); hi_acc = 1;
        end else if (v) begin
            hi_acc++;
        end
        prev_v = v;
    endtask

    task automatic check_all();
        chk("edge_pulse", edge_pulse, exp_ep);
        chk("period_valid", period_valid, exp_pv);
        chk("period", period, exp_period);
        chk("locked", locked, exp_lk);
        chk("timeout", timeout, exp_to);
`ifdef DUTY_MEASURE_EN
        if (exp_pv) chk("high_time", high_time, exp_ht);
`endif
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_edge_pulse"}, edge_pulse, 0);
        chk({tag, "_period_valid"}, period_valid, 0);
        chk({tag, "_period"}, period, 0);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_timeout"}, timeout, 0);
`ifdef DUTY_MEASURE_EN
        chk({tag, "_high_time"}, high_time, 0);
`endif
    endtask

    task automatic tick(input logic v);
        sig_in = v;
        @(posedge clk);
        model_edge(v);
        @(negedge clk);
        check_all();
    endtask

    task automatic gen_period(input int p, input int h);
        for (int i = 0; i < p; i++) tick(i < h);
    endtask

    initial begin
        int p, h, n;
        reset  = 1'b0;
        sig_in = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        reset = 1'b1;

        // divide-by-20, 50% duty: lock on the 4th rise
        repeat (5) gen_period(20, 10);
        chk("ph1_locked", locked, 1);
        chk("ph1_period", period, 20);
`ifdef DUTY_MEASURE_EN
        chk("ph1_high_time", high_time, 10);
`endif

        // one out-of-tolerance period, then relock
        gen_period(25, 12);
        gen_period(20, 10);
        chk("ph2_period25", period, 25);
        chk("ph2_unlocked", locked, 0);
        repeat (3) gen_period(20, 10);
        chk("ph2_relocked", locked, 1);

        // alternating 21/19 stays in tolerance
        repeat (3) begin
            gen_period(21, 10);
            gen_period(19, 9);
        end
        chk("ph3_locked", locked, 1);

        // signal loss, then recovery
        n = $urandom_range(1100, 1200);
        repeat (n) tick(1'b0);
        chk("ph4_timeout", timeout, 1);
        chk("ph4_locked", locked, 0);
        repeat (3) gen_period(20, 10);
        chk("ph4_recovered", timeout, 0);
        chk("ph4_period", period, 20);

        // rise exactly on the timeout boundary wins
        gen_period(TIMEOUT, 10);
        gen_period(20, 10);
        chk("ph5_period", period, TIMEOUT);
        chk("ph5_timeout", timeout, 0);

        // randomized periods and duty cycles
        repeat (30) begin
            p = $urandom_range(16, 26);
            h = $urandom_range(1, p - 1);
            gen_period(p, h);
        end

        // asynchronous reset mid-period while locked
        repeat (4) gen_period(20, 10);
        chk("ph7_locked", locked, 1);
        repeat (7) tick(1'b1);
        #3;
        reset = 1'b0;
        #1;
        check_zero("async_reset");
        model_reset();
        sig_in = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (5) gen_period(20, 10);
        chk("ph7_period", period, 20);
        chk("ph7_relocked", locked, 1);
`ifdef DUTY_MEASURE_EN
        chk("ph7_high_time", high_time, 10);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
